pe_brick_accum: RTL and testbench

Parametrised bit-brick processing element with a multi-beat accumulator. It splits each activation/weight word into 2-bit bricks, forms signed or unsigned brick products, sums them, and applies a precision-dependent left shift. Successive beats are accumulated with saturation until a tagged last beat. The group result is then presented on a valid/ready output port. It is the next-generation PE for the bit-brick array, replacing the fixed 16-brick, single-beat, non-accumulating PE.

---
 rtl/pe_brick_if.sv | 21 ++
 rtl/pe_brick_accum.sv | 84 ++++++++
 tb/tb_pe_brick_accum.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_brick_if.sv
// pe_brick_if: beat-input and group-result channels of pe_brick_accum
interface pe_brick_if #(
  parameter int N_BRICK = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  logic i_valid, o_ready, i_A_signed, i_W_signed, i_last;
  logic [2*N_BRICK-1:0] i_activation, i_weight;
  logic [3:0] i_shift_amount;
  logic o_valid, i_ready, o_overflow;
  logic signed [ACC_W-1:0] o_sum;
  logic [CNT_W-1:0] o_beats;
  modport slave (
    input i_valid, i_activation, i_weight, i_A_signed, i_W_signed, i_shift_amount, i_last, i_ready,
    output o_ready, o_valid, o_sum, o_overflow, o_beats
  );
  modport master (
    output i_valid, i_activation, i_weight, i_A_signed, i_W_signed, i_shift_amount, i_last, i_ready,
    input o_ready, o_valid, o_sum, o_overflow, o_beats
  );
endinterface

// File: rtl/pe_brick_accum.sv
// pe_brick_accum: 2-bit brick PE with a saturating multi-beat group accumulator
module pe_brick_accum #(
  parameter int N_BRICK = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input logic i_clk,
  input logic i_rst,
  pe_brick_if.slave bus
);
  localparam int SW = 5 + $clog2(N_BRICK);
  localparam logic [0:0] ST_ACC = 1'b0, ST_DONE = 1'b1;
  logic [0:0] r_state;
  logic r_s1_valid, r_s1_last, r_first, r_ovf;
  logic signed [ACC_W-1:0] r_s1, r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic signed [SW-1:0] w_bsum;
  logic [2:0] w_sh;
  logic w_accept, w_ovf;
  logic signed [ACC_W-1:0] w_base, w_sat;
  logic signed [ACC_W:0] w_add;

  function automatic logic signed [4:0] f_prod(input logic [1:0] a, input logic [1:0] w,
                                               input logic a_s, input logic w_s);
    logic signed [5:0] ea, ew, p;
    ea = 6'($signed({a_s & a[1], a}));
    ew = 6'($signed({w_s & w[1], w}));
    p = ea * ew;
    return p[4:0];
  endfunction

  always_comb begin
    w_bsum = '0;
    for (int k = 0; k < N_BRICK; k++)
      w_bsum = w_bsum + SW'(f_prod(bus.i_activation[2*k +: 2], bus.i_weight[2*k +: 2],
                                   bus.i_A_signed, bus.i_W_signed));
  end

  // the legal shifts 2/4/6 fit in three bits, so the low bits are the shift itself
  assign w_sh = (bus.i_shift_amount == 4'd2 || bus.i_shift_amount == 4'd4 ||
                 bus.i_shift_amount == 4'd6) ? bus.i_shift_amount[2:0] : 3'd0;
  assign bus.o_ready = r_state == ST_ACC && !(r_s1_valid && r_s1_last);
  assign w_accept = bus.i_valid && bus.o_ready;
  assign w_base = r_first ? '0 : r_acc;
  assign w_add = {w_base[ACC_W-1], w_base} + {r_s1[ACC_W-1], r_s1};
  assign w_ovf = w_add[ACC_W] ^ w_add[ACC_W-1];
  assign w_sat = w_ovf ? {w_add[ACC_W], {(ACC_W-1){~w_add[ACC_W]}}} : w_add[ACC_W-1:0];
  assign bus.o_valid = r_state == ST_DONE;
  assign bus.o_sum = r_acc;
  assign bus.o_overflow = r_ovf;
  assign bus.o_beats = r_cnt;

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1 <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1 <= {{(ACC_W-SW){w_bsum[SW-1]}}, w_bsum} << w_sh;
        r_s1_last <= bus.i_last;
      end
    end

  // r_first marks a restart: the next beat starts from zero instead of r_acc
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_state <= ST_ACC;
      r_first <= 1'b1;
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (r_s1_valid) begin
      r_acc <= w_sat;
      r_ovf <= (r_ovf && !r_first) || w_ovf;
      r_cnt <= r_first ? CNT_W'(1) : &r_cnt ? r_cnt : r_cnt + CNT_W'(1);
      r_first <= 1'b0;
      r_state <= r_s1_last ? ST_DONE : ST_ACC;
    end else if (r_state == ST_DONE && bus.i_ready) begin
      r_state <= ST_ACC;
      r_first <= 1'b1;
    end
endmodule

// File: tb/tb_pe_brick_accum.sv
// tb_pe_brick_accum: vector table, corner sequences and random groups vs an integer model
module tb_pe_brick_accum;
  localparam logic [31:0] A3 = 32'hFFFF_FFFF, A2 = 32'hAAAA_AAAA, A1 = 32'h5555_5555;
  localparam longint M24 = 8388607, M16 = 32767;

  typedef struct {
    logic [31:0] a, w;
    bit as, ws;
    logic [3:0] sh;
    int n, hold;
    longint e24;
    bit o24;
    longint e16;
    bit o16;
    int eb;
  } vec_t;

  typedef struct {
    longint s24, s16;
    bit o24, o16;
    int n;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic valid = 1'b0, a_s = 1'b0, w_s = 1'b0, last = 1'b0, rdy = 1'b0;
  logic [31:0] act = '0, wt = '0;
  logic [3:0] sh = '0;
  int n_cmp = 0, n_fail = 0;
  vec_t tab[10];
  exp_t q[$];
  logic [3:0] shs[6] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd6, 4'd9};
  longint m24, m16, ps24, ps16;
  bit mo24, mo16, m_first, pv;
  int mc, pb;

  always #5 clk = ~clk;

  pe_brick_if #(.N_BRICK(16), .ACC_W(24), .CNT_W(8)) bus ();
  pe_brick_if #(.N_BRICK(16), .ACC_W(16), .CNT_W(8)) bus16 ();

  assign bus.i_valid = valid;
  assign bus.i_activation = act;
  assign bus.i_weight = wt;
  assign bus.i_A_signed = a_s;
  assign bus.i_W_signed = w_s;
  assign bus.i_shift_amount = sh;
  assign bus.i_last = last;
  assign bus.i_ready = rdy;
  assign bus16.i_valid = valid;
  assign bus16.i_activation = act;
  assign bus16.i_weight = wt;
  assign bus16.i_A_signed = a_s;
  assign bus16.i_W_signed = w_s;
  assign bus16.i_shift_amount = sh;
  assign bus16.i_last = last;
  assign bus16.i_ready = rdy;

  pe_brick_accum #(.N_BRICK(16), .ACC_W(24), .CNT_W(8)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  pe_brick_accum #(.N_BRICK(16), .ACC_W(16), .CNT_W(8)) dut16 (.i_clk(clk), .i_rst(rst), .bus(bus16));

  task automatic chk(input string nm, input longint act_v, input longint exp_v);
    n_cmp++;
    if (act_v != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act_v, exp_v, $time);
    end
  endtask

  function automatic longint beat_value(input logic [31:0] a, input logic [31:0] w,
                                        input bit as, input bit ws, input logic [3:0] s);
    longint acc = 0;
    for (int k = 0; k < 16; k++) begin
      int x = int'(a[2*k +: 2]);
      int y = int'(w[2*k +: 2]);
      if (as && x > 1) x -= 4;
      if (ws && y > 1) y -= 4;
      acc += x * y;
    end
    return (s == 4'd2 || s == 4'd4 || s == 4'd6) ? acc * (longint'(1) << s) : acc;
  endfunction

  function automatic longint clamp(input longint v, input longint mx, output bit o);
    o = v > mx || v < -mx - 1;
    return v > mx ? mx : v < -mx - 1 ? -mx - 1 : v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_first = 1'b1;
    pv = 1'b0;
  endtask

  task automatic model_accept();
    longint v;
    bit o;
    v = beat_value(act, wt, a_s, w_s, sh);
    if (m_first) begin
      m24 = 0; m16 = 0; mo24 = 0; mo16 = 0; mc = 0;
    end
    m24 = clamp(m24 + v, M24, o);
    mo24 |= o;
    m16 = clamp(m16 + v, M16, o);
    mo16 |= o;
    mc = mc < 255 ? mc + 1 : 255;
    m_first = 1'b0;
    if (last) begin
      q.push_back('{m24, m16, mo24, mo16, mc});
      m_first = 1'b1;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pv) begin
          chk("hold_sum24", longint'($signed(bus.o_sum)), ps24);
          chk("hold_sum16", longint'($signed(bus16.o_sum)), ps16);
          chk("hold_beats", bus.o_beats, pb);
        end
        if (bus.o_valid && rdy) begin
          chk("result_pending", q.size() > 0, 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("res_sum24", longint'($signed(bus.o_sum)), e.s24);
            chk("res_ovf24", bus.o_overflow, e.o24);
            chk("res_sum16", longint'($signed(bus16.o_sum)), e.s16);
            chk("res_ovf16", bus16.o_overflow, e.o16);
            chk("res_beats", bus.o_beats, e.n);
            chk("res_valid16", bus16.o_valid, 1);
          end
        end
        pv = bus.o_valid && !rdy;
        ps24 = longint'($signed(bus.o_sum));
        ps16 = longint'($signed(bus16.o_sum));
        pb = int'(bus.o_beats);
        if (valid && bus.o_ready) model_accept();
      end
    end
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] w, input bit as, input bit ws,
                      input logic [3:0] s, input bit l);
    int n = 0;
    valid = 1'b1; act = a; wt = w; a_s = as; w_s = ws; sh = s; last = l;
    @(negedge clk);
    while (!bus.o_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("beat_accept", bus.o_ready, 1);
    @(posedge clk);
    #1 valid = 1'b0;
    last = 1'b0;
  endtask

  task automatic run_row(input int r);
    for (int i = 0; i < tab[r].n; i++)
      beat(tab[r].a, tab[r].w, tab[r].as, tab[r].ws, tab[r].sh, i == tab[r].n - 1);
    @(negedge clk);
    chk("s1_last_ready", bus.o_ready, 0);
    chk("s1_last_valid", bus.o_valid, 0);
    @(negedge clk);
    chk("done_valid", bus.o_valid, 1);
    chk("done_ready", bus.o_ready, 0);
    chk("row_sum24", longint'($signed(bus.o_sum)), tab[r].e24);
    chk("row_ovf24", bus.o_overflow, tab[r].o24);
    chk("row_sum16", longint'($signed(bus16.o_sum)), tab[r].e16);
    chk("row_ovf16", bus16.o_overflow, tab[r].o16);
    chk("row_beats", bus.o_beats, tab[r].eb);
    chk("row_beats16", bus16.o_beats, tab[r].eb);
    repeat (tab[r].hold) begin
      @(negedge clk);
      chk("stall_valid", bus.o_valid, 1);
      chk("stall_ready", bus.o_ready, 0);
    end
    @(posedge clk);
    #1 rdy = 1'b1;
    @(negedge clk);
    chk("hs_ready", bus.o_ready, 0);
    @(posedge clk);
    #1 rdy = 1'b0;
    @(negedge clk);
    chk("post_valid", bus.o_valid, 0);
    chk("post_ready", bus.o_ready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nb, n;
    tab[0] = '{A3, A3, 1'b0, 1'b0, 4'd0, 1, 0, 144, 1'b0, 144, 1'b0, 1};
    tab[1] = '{A2, A2, 1'b1, 1'b1, 4'd6, 1, 0, 4096, 1'b0, 4096, 1'b0, 1};
    tab[2] = '{A3, A3, 1'b1, 1'b0, 4'd3, 3, 0, -144, 1'b0, -144, 1'b0, 3};
    tab[3] = '{A3, A3, 1'b0, 1'b0, 4'd6, 4, 5, 36864, 1'b0, 32767, 1'b1, 4};
    tab[4] = '{A3, A3, 1'b0, 1'b0, 4'd0, 1, 0, 144, 1'b0, 144, 1'b0, 1};
    tab[5] = '{A1, A2, 1'b0, 1'b1, 4'd4, 2, 1, -1024, 1'b0, -1024, 1'b0, 2};
    tab[6] = '{32'h0, A3, 1'b1, 1'b1, 4'd2, 1, 0, 0, 1'b0, 0, 1'b0, 1};
    tab[7] = '{A2, A3, 1'b1, 1'b0, 4'd6, 6, 0, -36864, 1'b0, -32768, 1'b1, 6};
    tab[8] = '{A3, A3, 1'b0, 1'b0, 4'd0, 260, 0, 37440, 1'b0, 32767, 1'b1, 255};
    tab[9] = '{32'h1B1B_1B1B, 32'hE4E4_E4E4, 1'b1, 1'b1, 4'd4, 1, 0, -256, 1'b0, -256, 1'b0, 1};
    model_reset();
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_sum", longint'($signed(bus.o_sum)), 0);
    chk("rst_ovf", bus.o_overflow, 0);
    chk("rst_beats", bus.o_beats, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.o_ready, 1);
    @(posedge clk);
    #1;
    for (int r = 0; r < 10; r++) run_row(r);
    // reset in the middle of a group, between clock edges
    beat(A3, A3, 1'b0, 1'b0, 4'd0, 1'b0);
    beat(A3, A3, 1'b0, 1'b0, 4'd0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", bus.o_valid, 0);
    chk("midrst_sum", longint'($signed(bus.o_sum)), 0);
    chk("midrst_sum16", longint'($signed(bus16.o_sum)), 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    run_row(0);
    for (int g = 0; g < 40; g++) begin
      nb = $urandom_range(1, 5);
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             shs[$urandom_range(0, 5)], i == nb - 1);
      end
      n = 0;
      while (q.size() != 0 && n < 60) begin
        rdy = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        n++;
      end
      rdy = 1'b0;
      chk("drain", q.size(), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
